// File: rtl/update_bin_packer.sv
// Per-bin update coalescer. Incoming {update,dest_vid} words go to one accumulator per
// partition bin. A bin that fills emits one packed DRAM line. The flush mode drains every
// partially filled bin as a zero-padded line that carries its word count.
module update_bin_packer #(
    parameter int unsigned UPD_W      = 64,
    parameter int unsigned LINE_W     = 512,
    parameter int unsigned PAR_NUM    = 16,
    parameter int unsigned PAR_NUM_W  = 4,
    parameter int unsigned PAR_SIZE_W = 17,
    localparam int unsigned WORDS     = LINE_W / UPD_W,
    localparam int unsigned CNT_W     = $clog2(WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [UPD_W-1:0]     word_in,
    input  logic                 word_in_valid,
    output logic                 word_in_ready,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [LINE_W-1:0]    DRAM_W,
    output logic                 DRAM_W_valid,
    input  logic                 DRAM_W_ready,
    output logic [PAR_NUM_W-1:0] DRAM_W_bin,
    output logic [CNT_W-1:0]     DRAM_W_cnt,
    output logic [PAR_NUM-1:0]   bin_nonempty
);

    typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

    state_e                 state_q, state_d;
    logic [PAR_NUM_W-1:0]   scan_q, scan_d;
    logic [LINE_W-1:0]      acc_q   [PAR_NUM];
    logic [LINE_W-1:0]      acc_d   [PAR_NUM];
    logic [CNT_W-1:0]       count_q [PAR_NUM];
    logic [CNT_W-1:0]       count_d [PAR_NUM];

    logic [LINE_W-1:0]      line_q, line_d;
    logic                   line_valid_q, line_valid_d;
    logic [PAR_NUM_W-1:0]   line_bin_q, line_bin_d;
    logic [CNT_W-1:0]       line_cnt_q, line_cnt_d;

    logic                   slot_free;
    logic                   accept;
    logic [PAR_NUM_W-1:0]   in_bin;
    logic                   scan_has_data;
    int unsigned            pad_shift;

    assign slot_free     = !line_valid_q || DRAM_W_ready;
    assign word_in_ready = (state_q == StRun) && slot_free;
    assign accept        = word_in_valid && word_in_ready;
    assign in_bin        = word_in[PAR_SIZE_W+PAR_NUM_W-1:PAR_SIZE_W];
    assign scan_has_data = (count_q[scan_q] != '0);
    // Shift a partial bin up so its first word lands in the MS slot; low slots become zero.
    assign pad_shift     = UPD_W * (WORDS - 32'(count_q[scan_q]));

    assign flush_done    = (state_q == StDone);
    assign DRAM_W        = line_q;
    assign DRAM_W_valid  = line_valid_q;
    assign DRAM_W_bin    = line_bin_q;
    assign DRAM_W_cnt    = line_cnt_q;

    // Occupancy flags straight from the registered counts.
    always_comb begin
        bin_nonempty = '0;
        for (int p = 0; p < int'(PAR_NUM); p++) begin
            bin_nonempty[p] = (count_q[p] != '0);
        end
    end

    // Next-state: accumulate/complete lines in RUN, scan and drain bins in FLUSH.
    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q;
        acc_d        = acc_q;
        count_d      = count_q;
        line_d       = line_q;
        line_valid_d = line_valid_q;
        line_bin_d   = line_bin_q;
        line_cnt_d   = line_cnt_q;

        // The slot empties when its line is taken; a load below overrides this.
        if (slot_free) begin
            line_valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (count_q[in_bin] == CNT_W'(WORDS - 1)) begin
                        line_d          = {acc_q[in_bin][LINE_W-UPD_W-1:0], word_in};
                        line_valid_d    = 1'b1;
                        line_bin_d      = in_bin;
                        line_cnt_d      = CNT_W'(WORDS);
                        acc_d[in_bin]   = '0;
                        count_d[in_bin] = '0;
                    end else begin
                        acc_d[in_bin]   = (acc_q[in_bin] << UPD_W) | LINE_W'(word_in);
                        count_d[in_bin] = count_q[in_bin] + CNT_W'(1);
                    end
                end
                // A word accepted this same cycle is already in its bin when the scan starts.
                if (flush) begin
                    state_d = StFlush;
                    scan_d  = '0;
                end
            end
            StFlush: begin
                if (!scan_has_data || slot_free) begin
                    if (scan_has_data) begin
                        line_d          = acc_q[scan_q] << pad_shift;
                        line_valid_d    = 1'b1;
                        line_bin_d      = scan_q;
                        line_cnt_d      = count_q[scan_q];
                        acc_d[scan_q]   = '0;
                        count_d[scan_q] = '0;
                    end
                    if (scan_q == PAR_NUM_W'(PAR_NUM - 1)) begin
                        state_d = StDone;
                    end else begin
                        scan_d = scan_q + PAR_NUM_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State, accumulators and the single-slot output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            scan_q       <= '0;
            acc_q        <= '{default: '0};
            count_q      <= '{default: '0};
            line_q       <= '0;
            line_valid_q <= 1'b0;
            line_bin_q   <= '0;
            line_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            line_bin_q   <= line_bin_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

endmodule

// File: tb/tb_update_bin_packer.sv
// Randomized, self-checking bench for update_bin_packer. The reference model keeps one queue
// of words per bin and builds expected lines by placing words into slots.
module tb_update_bin_packer;

    localparam int UPD_W  = 64;
    localparam int LINE_W = 512;
    localparam int NB     = 16;
    localparam int WORDS  = 8;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [3:0]        bin;
        logic [3:0]        cnt;
    } line_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [UPD_W-1:0]  word_in = '0;
    logic              word_in_valid = 1'b0;
    logic              word_in_ready;
    logic              flush = 1'b0;
    logic              flush_done;
    logic [LINE_W-1:0] DRAM_W;
    logic              DRAM_W_valid;
    logic              DRAM_W_ready = 1'b1;
    logic [3:0]        DRAM_W_bin;
    logic [3:0]        DRAM_W_cnt;
    logic [NB-1:0]     bin_nonempty;

    int checks = 0;
    int failures = 0;

    logic [UPD_W-1:0] mq [NB][$];
    line_t            exp_q[$];
    line_t            got_q[$];

    update_bin_packer dut (
        .clk          (clk),
        .rst          (rst),
        .word_in      (word_in),
        .word_in_valid(word_in_valid),
        .word_in_ready(word_in_ready),
        .flush        (flush),
        .flush_done   (flush_done),
        .DRAM_W       (DRAM_W),
        .DRAM_W_valid (DRAM_W_valid),
        .DRAM_W_ready (DRAM_W_ready),
        .DRAM_W_bin   (DRAM_W_bin),
        .DRAM_W_cnt   (DRAM_W_cnt),
        .bin_nonempty (bin_nonempty)
    );

    always #5 clk = ~clk;

    // Record every line handed over downstream.
    always @(posedge clk) begin
        if (rst && DRAM_W_valid && DRAM_W_ready) begin
            got_q.push_back(line_t'({DRAM_W, DRAM_W_bin, DRAM_W_cnt}));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [UPD_W-1:0] mkword(input int b);
        logic [UPD_W-1:0] w;
        w = {$urandom(), $urandom()};
        w[20:17] = 4'(b);
        return w;
    endfunction

    function automatic line_t make_line(input int b);
        line_t e;
        e.line = '0;
        e.bin  = 4'(b);
        e.cnt  = 4'(mq[b].size());
        for (int i = 0; i < mq[b].size(); i++) begin
            e.line[LINE_W-1-UPD_W*i -: UPD_W] = mq[b][i];
        end
        return e;
    endfunction

    function automatic logic [NB-1:0] exp_nonempty();
        logic [NB-1:0] r;
        for (int p = 0; p < NB; p++) r[p] = (mq[p].size() != 0);
        return r;
    endfunction

    task automatic model_push(input logic [UPD_W-1:0] w);
        int b;
        b = int'(w[20:17]);
        mq[b].push_back(w);
        if (mq[b].size() == WORDS) begin
            exp_q.push_back(make_line(b));
            mq[b].delete();
        end
    endtask

    task automatic model_flush();
        for (int p = 0; p < NB; p++) begin
            if (mq[p].size() != 0) begin
                exp_q.push_back(make_line(p));
                mq[p].delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one word until accepted (bounded); the model sees it only on acceptance.
    task automatic send(input logic [UPD_W-1:0] w);
        bit done;
        done = 1'b0;
        word_in = w;
        word_in_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            #1;
            done = word_in_ready;
            tick();
        end
        word_in_valid = 1'b0;
        if (done) begin
            model_push(w);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %h never accepted (ready stayed 0, want 1)", w);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_flush_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (flush_done) seen = 1'b1;
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: flush_done got 0 within 200 cycles, want 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        DRAM_W_ready = 1'b1;
        #17;
        checks++;
        if ({DRAM_W_valid, flush_done, DRAM_W_bin, DRAM_W_cnt, bin_nonempty} !== '0
            || DRAM_W !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b done=%b bin=%0d cnt=%0d ne=%h, want all 0",
                     DRAM_W_valid, flush_done, DRAM_W_bin, DRAM_W_cnt, bin_nonempty);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (word_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: word_in_ready got %b want 1", word_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [UPD_W-1:0] w [WORDS];
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            w[i] = mkword(3);
            send(w[i]);
            if (i == WORDS - 2) begin
                checks++;
                if (DRAM_W_valid !== 1'b0 || bin_nonempty !== 16'h0008) begin
                    failures++;
                    $display("FAIL fill_partial: valid=%b ne=%h, want 0 and 0008",
                             DRAM_W_valid, bin_nonempty);
                end
            end
        end
        checks++;
        if (DRAM_W_valid !== 1'b1 || DRAM_W_cnt !== 4'd8 || DRAM_W_bin !== 4'd3) begin
            failures++;
            $display("FAIL fill_latency: valid=%b cnt=%0d bin=%0d, want 1 8 3",
                     DRAM_W_valid, DRAM_W_cnt, DRAM_W_bin);
        end
        checks++;
        if (DRAM_W[511:448] !== w[0] || DRAM_W[63:0] !== w[WORDS-1]) begin
            failures++;
            $display("FAIL fill_order: ms=%h ls=%h, want %h %h",
                     DRAM_W[511:448], DRAM_W[63:0], w[0], w[WORDS-1]);
        end
        tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL fill_line: got %0d lines, want 1 matching line", got_q.size());
        end
    endtask

    task automatic test_interleave();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 2 * WORDS; i++) send(mkword((i % 2 == 0) ? 0 : 15));
        tick();
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
            failures++;
            $display("FAIL interleave_count: got %0d lines want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL interleave_line%0d: got bin=%0d cnt=%0d want bin=%0d cnt=%0d",
                         i, got_q[i].bin, got_q[i].cnt, exp_q[i].bin, exp_q[i].cnt);
            end
        end
        checks++;
        if (bin_nonempty !== '0) begin
            failures++;
            $display("FAIL interleave_empty: bin_nonempty got %h want 0", bin_nonempty);
        end
    endtask

    task automatic test_backpressure();
        logic [LINE_W-1:0] snap;
        logic [UPD_W-1:0]  extra;
        got_q.delete();
        exp_q.delete();
        DRAM_W_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) send(mkword(5));
        snap = DRAM_W;
        extra = mkword(5);
        word_in = extra;
        word_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (word_in_ready !== 1'b0 || DRAM_W_valid !== 1'b1 || DRAM_W !== snap
                || DRAM_W_cnt !== 4'd8 || DRAM_W_bin !== 4'd5) begin
                failures++;
                $display("FAIL bp_hold%0d: ready=%b valid=%b cnt=%0d bin=%0d stable=%b, want 0 1 8 5 1",
                         k, word_in_ready, DRAM_W_valid, DRAM_W_cnt, DRAM_W_bin, DRAM_W === snap);
            end
            tick();
        end
        DRAM_W_ready = 1'b1;
        #1;
        checks++;
        if (word_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: word_in_ready got %b want 1", word_in_ready);
        end
        tick();
        word_in_valid = 1'b0;
        model_push(extra);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]
            || bin_nonempty !== exp_nonempty()) begin
            failures++;
            $display("FAIL bp_line: got %0d lines ne=%h, want 1 line ne=%h",
                     got_q.size(), bin_nonempty, exp_nonempty());
        end
        for (int i = 0; i < WORDS - 1; i++) send(mkword(5));
        tick();
    endtask

    task automatic test_flush();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) send(mkword(2));
        send(mkword(9));
        pulse_flush();
        model_flush();
        wait_flush_done("flush");
        tick();
        checks++;
        if (got_q.size() != 2) begin
            failures++;
            $display("FAIL flush_count: got %0d lines want 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL flush_line%0d: got bin=%0d cnt=%0d data=%h want bin=%0d cnt=%0d data=%h",
                         i, got_q[i].bin, got_q[i].cnt, got_q[i].line,
                         exp_q[i].bin, exp_q[i].cnt, exp_q[i].line);
            end
        end
        checks++;
        if (bin_nonempty !== '0) begin
            failures++;
            $display("FAIL flush_empty: bin_nonempty got %h want 0", bin_nonempty);
        end
    endtask

    task automatic test_empty_flush();
        int  n;
        bit  saw_valid;
        saw_valid = 1'b0;
        pulse_flush();
        n = 1;
        while (n < 40 && !flush_done) begin
            if (DRAM_W_valid) saw_valid = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n != NB + 1) begin
            failures++;
            $display("FAIL empty_flush_latency: flush_done after %0d cycles want %0d", n, NB + 1);
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("FAIL empty_flush_valid: DRAM_W_valid got 1 want 0");
        end
        tick();
        checks++;
        if (flush_done !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush_pulse: flush_done got %b want 0 (one cycle)", flush_done);
        end
    endtask

    task automatic test_reset_flush();
        bit saw_done;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) send(mkword(1));
        for (int i = 0; i < 2; i++) send(mkword(12));
        pulse_flush();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({DRAM_W_valid, flush_done, DRAM_W_bin, DRAM_W_cnt, bin_nonempty} !== '0
            || DRAM_W !== '0) begin
            failures++;
            $display("FAIL rstflush_outputs: valid=%b done=%b bin=%0d cnt=%0d ne=%h, want all 0",
                     DRAM_W_valid, flush_done, DRAM_W_bin, DRAM_W_cnt, bin_nonempty);
        end
        for (int p = 0; p < NB; p++) mq[p].delete();
        @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 25; k++) begin
            if (flush_done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL rstflush_done: flush_done got 1 after reset want 0");
        end
        for (int i = 0; i < WORDS; i++) send(mkword(0));
        tick();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL rstflush_line: got %0d lines (cnt=%0d), want 1 clean cnt=8 line",
                     got_q.size(), (got_q.size() != 0) ? got_q[0].cnt : 4'd0);
        end
    endtask

    task automatic test_random();
        bit               acc;
        bit               ne_bad;
        logic [UPD_W-1:0] w;
        got_q.delete();
        exp_q.delete();
        ne_bad = 1'b0;
        for (int c = 0; c < 800; c++) begin
            w = mkword(($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NB - 1));
            word_in = w;
            word_in_valid = ($urandom_range(0, 3) != 0);
            DRAM_W_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = word_in_valid && word_in_ready;
            tick();
            if (acc) model_push(w);
            if (bin_nonempty !== exp_nonempty()) ne_bad = 1'b1;
        end
        word_in_valid = 1'b0;
        DRAM_W_ready = 1'b1;
        checks++;
        if (ne_bad) begin
            failures++;
            $display("FAIL random_nonempty: bin_nonempty diverged from model");
        end
        tick();
        pulse_flush();
        model_flush();
        wait_flush_done("random");
        tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d lines want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_line%0d: got bin=%0d cnt=%0d data=%h want bin=%0d cnt=%0d data=%h",
                         i, got_q[i].bin, got_q[i].cnt, got_q[i].line,
                         exp_q[i].bin, exp_q[i].cnt, exp_q[i].line);
            end
        end
        checks++;
        if (bin_nonempty !== '0) begin
            failures++;
            $display("FAIL random_empty: bin_nonempty got %h want 0", bin_nonempty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_interleave();
        test_backpressure();
        test_flush();
        test_empty_flush();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
